// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: initial AddRoundKey inside, external round datapath per cycle.
// Optional macro AES_SEQ_DECRYPT_EN adds in_decrypt/round_decrypt and reverse key order.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_IDX_W  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  // Handshake: a block moves on a rising edge where valid and ready are both high; valid
  // never waits on ready, and out_valid/out_data stay stable until that edge.
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         key_data,
  output logic [127:0]         round_in,
  output logic [127:0]         round_key,
  output logic                 round_final,
  input  logic [127:0]         round_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 busy,
`ifdef AES_SEQ_DECRYPT_EN
  input  logic                 in_decrypt,
  output logic                 round_decrypt,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NUM_ROUNDS);
  localparam logic [KEY_IDX_W-1:0] ONE_IDX  = KEY_IDX_W'(1);

  if ((2 ** KEY_IDX_W) <= NUM_ROUNDS) begin : g_bad_key_idx_w
    $error("aes_round_sequencer: KEY_IDX_W too narrow for NUM_ROUNDS");
  end

  state_e               state_q, state_d;
  logic [127:0]         data_q, data_d;
  logic [127:0]         out_q, out_d;
  logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
  logic [KEY_IDX_W-1:0] key_idx_q, key_idx_d;
  logic [KEY_IDX_W-1:0] key_step;
  logic [KEY_IDX_W-1:0] first_idx;
  logic                 decrypt_mode;

`ifdef AES_SEQ_DECRYPT_EN
  logic decrypt_q, decrypt_d;
  assign decrypt_mode  = decrypt_q;
  assign first_idx     = in_decrypt ? LAST_IDX : '0;
  assign round_decrypt = decrypt_q;
`else
  assign decrypt_mode  = 1'b0;
  assign first_idx     = '0;
`endif

  // The key RAM answers during the cycle after an address is registered, so key_idx
  // always points at the key the next state will consume; it saturates at either end.
  always_comb begin
    key_step = key_idx_q;
    if (decrypt_mode) begin
      if (key_idx_q != '0) key_step = key_idx_q - ONE_IDX;
    end else begin
      if (key_idx_q != LAST_IDX) key_step = key_idx_q + ONE_IDX;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    out_d     = out_q;
    rnd_d     = rnd_q;
    key_idx_d = key_idx_q;
`ifdef AES_SEQ_DECRYPT_EN
    decrypt_d = decrypt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          key_idx_d = first_idx;
          rnd_d     = '0;
`ifdef AES_SEQ_DECRYPT_EN
          decrypt_d = in_decrypt;
`endif
          state_d   = INIT;
        end
      end
      INIT: begin
        data_d    = data_q ^ key_data;
        key_idx_d = key_step;
        rnd_d     = ONE_IDX;
        state_d   = ROUND;
      end
      ROUND: begin
        data_d    = round_out;
        key_idx_d = key_step;
        if (rnd_q == LAST_IDX) begin
          out_d   = round_out;
          state_d = DONE;
        end else begin
          rnd_d   = rnd_q + ONE_IDX;
        end
      end
      DONE: begin
        if (out_ready) begin
          key_idx_d = '0;
          rnd_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      out_q     <= '0;
      rnd_q     <= '0;
      key_idx_q <= '0;
`ifdef AES_SEQ_DECRYPT_EN
      decrypt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      out_q     <= out_d;
      rnd_q     <= rnd_d;
      key_idx_q <= key_idx_d;
`ifdef AES_SEQ_DECRYPT_EN
      decrypt_q <= decrypt_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_data    = out_q;
  assign round_in    = data_q;
  assign round_key   = key_data;
  assign round_final = (state_q == ROUND) && (rnd_q == LAST_IDX);
  assign key_idx     = key_idx_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed FIPS-197 bench for aes_round_sequencer: bench-side round datapath and key RAM,
// one AES-128 instance and one AES-256 instance.
module tb_aes_round_sequencer;

  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R1_C1  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // ---------------- AES-128 instance ----------------
  logic         in_valid, in_ready, out_valid, out_ready, busy, round_final;
  logic [127:0] in_data, key_data, round_in, round_key, round_out, out_data;
  logic [3:0]   key_idx;
  logic [1:0]   dbg_state;
  logic [127:0] key_mem [16];

  // ---------------- AES-256 instance ----------------
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b, round_final_b;
  logic [127:0] in_data_b, key_data_b, round_in_b, round_key_b, round_out_b, out_data_b;
  logic [3:0]   key_idx_b;
  logic [1:0]   dbg_state_b;
  logic [127:0] key_mem_b [16];

`ifdef AES_SEQ_DECRYPT_EN
  logic in_decrypt, round_decrypt, in_decrypt_b, round_decrypt_b;
`endif

  aes_round_sequencer #(.NUM_ROUNDS(10), .KEY_IDX_W(4)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_data(key_data),
    .round_in(round_in), .round_key(round_key), .round_final(round_final), .round_out(round_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
`ifdef AES_SEQ_DECRYPT_EN
    .in_decrypt(in_decrypt), .round_decrypt(round_decrypt),
`endif
    .dbg_state(dbg_state)
  );

  aes_round_sequencer #(.NUM_ROUNDS(14), .KEY_IDX_W(4)) u_dut_b (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .key_idx(key_idx_b), .key_data(key_data_b),
    .round_in(round_in_b), .round_key(round_key_b), .round_final(round_final_b), .round_out(round_out_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b),
`ifdef AES_SEQ_DECRYPT_EN
    .in_decrypt(in_decrypt_b), .round_decrypt(round_decrypt_b),
`endif
    .dbg_state(dbg_state_b)
  );

  // ---------------- AES reference pieces ----------------
  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  // One cipher round (or inverse-cipher round when dec is set); fin drops (Inv)MixColumns.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin, input logic dec);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   b0, b1, b2, b3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        if (dec) b[row+4*c] = inv_sbox[a[row+4*((c-row+4)%4)]];
        else     b[row+4*c] = sbox[a[row+4*((c+row)%4)]];
    if (dec) for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      b0 = b[4*c]; b1 = b[4*c+1]; b2 = b[4*c+2]; b3 = b[4*c+3];
      if (fin) begin
        a[4*c] = b0; a[4*c+1] = b1; a[4*c+2] = b2; a[4*c+3] = b3;
      end else if (dec) begin
        a[4*c]   = gmul(b0,8'h0e) ^ gmul(b1,8'h0b) ^ gmul(b2,8'h0d) ^ gmul(b3,8'h09);
        a[4*c+1] = gmul(b0,8'h09) ^ gmul(b1,8'h0e) ^ gmul(b2,8'h0b) ^ gmul(b3,8'h0d);
        a[4*c+2] = gmul(b0,8'h0d) ^ gmul(b1,8'h09) ^ gmul(b2,8'h0e) ^ gmul(b3,8'h0b);
        a[4*c+3] = gmul(b0,8'h0b) ^ gmul(b1,8'h0d) ^ gmul(b2,8'h09) ^ gmul(b3,8'h0e);
      end else begin
        a[4*c]   = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
        a[4*c+1] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
        a[4*c+2] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
        a[4*c+3] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
      end
    end
    if (!dec) for (int i = 0; i < 16; i++) a[i] = a[i] ^ k[127-8*i -: 8];
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
    return r;
  endfunction

  task automatic load_keys(input logic [255:0] key, input int nk, input int nr, input bit to_b);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      if (to_b) key_mem_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else      key_mem[r]   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Key RAM: key_idx is the registered address, data appears in the following cycle.
  assign key_data   = key_mem[key_idx];
  assign key_data_b = key_mem_b[key_idx_b];
`ifdef AES_SEQ_DECRYPT_EN
  assign round_out   = aes_round(round_in, round_key, round_final, round_decrypt);
  assign round_out_b = aes_round(round_in_b, round_key_b, round_final_b, round_decrypt_b);
`else
  assign round_out   = aes_round(round_in, round_key, round_final, 1'b0);
  assign round_out_b = aes_round(round_in_b, round_key_b, round_final_b, 1'b0);
`endif

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q [$];
  logic [127:0] exp;
  int tests  = 0;
  int failed = 0;

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (key_idx !== 4'd0) begin failed++; $display("FAIL reset_key_idx: got %0d want 0", key_idx); end
    tests++; if (round_final !== 1'b0) begin failed++; $display("FAIL reset_round_final: got %b want 0", round_final); end
    tests++; if (round_in !== 128'h0) begin failed++; $display("FAIL reset_round_in: got %h want 0", round_in); end
    tests++; if (dbg_state !== 2'd0) begin failed++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    tests++; if (in_ready_b !== 1'b1 || busy_b !== 1'b0 || key_idx_b !== 4'd0 || dbg_state_b !== 2'd0) begin
      failed++; $display("FAIL reset_dut_b: got ready=%b busy=%b idx=%0d st=%0d want 1 0 0 0",
                         in_ready_b, busy_b, key_idx_b, dbg_state_b);
    end
    reset_n = 1'b1;
    @(negedge clock);
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fips128();
    int n;
    exp_q.push_back(CT_C1);
    in_data = PT_C1; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock); n++;
      in_valid = 1'b0;
      if (!out_valid) begin
        tests++; if (key_idx !== 4'(n-1)) begin failed++; $display("FAIL c1_key_idx step %0d: got %0d want %0d", n, key_idx, n-1); end
        tests++; if (round_final !== (n == 11)) begin failed++; $display("FAIL c1_round_final step %0d: got %b want %b", n, round_final, (n == 11)); end
        if (n == 1) begin
          tests++; if (round_in !== PT_C1) begin failed++; $display("FAIL c1_capture: got %h want %h", round_in, PT_C1); end
        end
        if (n == 2) begin
          tests++; if (round_in !== R1_C1) begin failed++; $display("FAIL c1_initial_ark: got %h want %h", round_in, R1_C1); end
        end
      end
    end
    tests++; if (!out_valid) begin failed++; $display("FAIL c1_timeout: got no out_valid want out_valid within 40 cycles"); end
    tests++; if (n !== 12) begin failed++; $display("FAIL c1_latency: got %0d want 12", n); end
    exp = exp_q.pop_front();
    tests++; if (out_data !== exp) begin failed++; $display("FAIL c1_ciphertext: got %h want %h", out_data, exp); end
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL c1_in_ready_done: got %b want 0", in_ready); end
    @(negedge clock);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || key_idx !== 4'd0) begin
      failed++; $display("FAIL c1_return_idle: got valid=%b ready=%b idx=%0d want 0 1 0", out_valid, in_ready, key_idx);
    end
  endtask

  task automatic test_back_to_back();
    int n, acc_cnt, out_cnt;
    int acc_n [2];
    exp_q.push_back(CT_C1); exp_q.push_back(CT_C1);
    in_data = PT_C1; in_valid = 1'b1; out_ready = 1'b1;
    acc_n[0] = 0; acc_n[1] = 0;
    n = 0; acc_cnt = 0; out_cnt = 0;
    while (out_cnt < 2 && n < 80) begin
      if (in_valid && in_ready && acc_cnt < 2) begin acc_n[acc_cnt] = n; acc_cnt++; end
      if (out_valid) begin
        out_cnt++;
        tests++;
        if (exp_q.size() == 0) begin failed++; $display("FAIL b2b_extra_output: got %h want none", out_data); end
        else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin failed++; $display("FAIL b2b_ciphertext %0d: got %h want %h", out_cnt, out_data, exp); end
        end
      end
      @(negedge clock); n++;
      if (acc_cnt == 2) in_valid = 1'b0;
    end
    tests++; if (out_cnt !== 2) begin failed++; $display("FAIL b2b_outputs: got %0d want 2", out_cnt); end
    tests++; if (acc_cnt !== 2 || acc_n[1] - acc_n[0] !== 13) begin
      failed++; $display("FAIL b2b_accept_spacing: got %0d want 13", acc_n[1] - acc_n[0]);
    end
    in_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int n;
    in_data = PT_C1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    tests++; if (key_idx !== 4'd5 || busy !== 1'b1) begin failed++; $display("FAIL mid_round5: got idx=%0d busy=%b want 5 1", key_idx, busy); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failed++; $display("FAIL mid_async_flags: got ready=%b busy=%b valid=%b want 1 0 0", in_ready, busy, out_valid);
    end
    tests++; if (key_idx !== 4'd0 || round_final !== 1'b0 || round_in !== 128'h0 || dbg_state !== 2'd0) begin
      failed++; $display("FAIL mid_async_regs: got idx=%0d fin=%b in=%h st=%0d want 0 0 0 0", key_idx, round_final, round_in, dbg_state);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL mid_discarded: got valid=%b busy=%b want 0 0", out_valid, busy); end
    exp_q.push_back(CT_C1);
    in_data = PT_C1; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clock); n++; end
    tests++; if (n !== 12) begin failed++; $display("FAIL mid_restart_latency: got %0d want 12", n); end
    exp = exp_q.pop_front();
    tests++; if (out_data !== exp) begin failed++; $display("FAIL mid_restart_ciphertext: got %h want %h", out_data, exp); end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    int n;
    exp_q.push_back(CT_B); exp_q.push_back(CT_B);
    in_data = PT_B; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clock); n++; end
    tests++; if (!out_valid) begin failed++; $display("FAIL bp_timeout: got no out_valid want out_valid within 40 cycles"); end
    exp = exp_q.pop_front();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL bp_valid_hold %0d: got %b want 1", i, out_valid); end
      tests++; if (out_data !== exp) begin failed++; $display("FAIL bp_data_hold %0d: got %h want %h", i, out_data, exp); end
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_in_ready %0d: got %b want 0", i, in_ready); end
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL bp_after_handshake: got valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    @(negedge clock);
    in_valid = 1'b0;
    tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failed++; $display("FAIL bp_second_accept: got busy=%b ready=%b want 1 0", busy, in_ready); end
    n = 1;
    while (!out_valid && n < 40) begin @(negedge clock); n++; end
    exp = exp_q.pop_front();
    tests++; if (out_data !== exp || out_valid !== 1'b1) begin
      failed++; $display("FAIL bp_second_ciphertext: got %h valid=%b want %h", out_data, out_valid, exp);
    end
    @(negedge clock);
  endtask

  task automatic test_aes256();
    int n;
    exp_q.push_back(CT_C3);
    in_data_b = PT_C1; in_valid_b = 1'b1; out_ready_b = 1'b1;
    n = 0;
    while (!out_valid_b && n < 40) begin
      @(negedge clock); n++;
      in_valid_b = 1'b0;
      if (!out_valid_b) begin
        tests++; if (key_idx_b !== 4'(n-1)) begin failed++; $display("FAIL c3_key_idx step %0d: got %0d want %0d", n, key_idx_b, n-1); end
        tests++; if (round_final_b !== (n == 15)) begin failed++; $display("FAIL c3_round_final step %0d: got %b want %b", n, round_final_b, (n == 15)); end
      end
    end
    tests++; if (n !== 16) begin failed++; $display("FAIL c3_latency: got %0d want 16", n); end
    exp = exp_q.pop_front();
    tests++; if (out_data_b !== exp) begin failed++; $display("FAIL c3_ciphertext: got %h want %h", out_data_b, exp); end
    @(negedge clock);
    tests++; if (in_ready_b !== 1'b1 || key_idx_b !== 4'd0) begin failed++; $display("FAIL c3_idle: got ready=%b idx=%0d want 1 0", in_ready_b, key_idx_b); end
  endtask

`ifdef AES_SEQ_DECRYPT_EN
  task automatic test_decrypt();
    int n;
    exp_q.push_back(PT_C1);
    in_data = CT_C1; in_decrypt = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock); n++;
      in_valid = 1'b0; in_decrypt = 1'b0;
      if (!out_valid) begin
        tests++; if (key_idx !== ((n == 1) ? 4'd10 : 4'(11-n))) begin
          failed++; $display("FAIL dec_key_idx step %0d: got %0d want %0d", n, key_idx, (n == 1) ? 10 : 11-n);
        end
        tests++; if (round_decrypt !== 1'b1) begin failed++; $display("FAIL dec_mode step %0d: got %b want 1", n, round_decrypt); end
        tests++; if (round_final !== (n == 11)) begin failed++; $display("FAIL dec_round_final step %0d: got %b want %b", n, round_final, (n == 11)); end
      end
    end
    tests++; if (n !== 12) begin failed++; $display("FAIL dec_latency: got %0d want 12", n); end
    exp = exp_q.pop_front();
    tests++; if (out_data !== exp) begin failed++; $display("FAIL dec_plaintext: got %h want %h", out_data, exp); end
    @(negedge clock);
  endtask
`endif

  // ---------------- main sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
`ifdef AES_SEQ_DECRYPT_EN
    in_decrypt = 1'b0; in_decrypt_b = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin key_mem[i] = '0; key_mem_b[i] = '0; end
    init_sbox();
    load_keys({KEY_C1, 128'h0}, 4, 10, 1'b0);
    load_keys(KEY_C3, 8, 14, 1'b1);
    test_reset();
    test_fips128();
    test_back_to_back();
    test_reset_mid();
    load_keys({KEY_B, 128'h0}, 4, 10, 1'b0);
    test_backpressure();
    test_aes256();
`ifdef AES_SEQ_DECRYPT_EN
    load_keys({KEY_C1, 128'h0}, 4, 10, 1'b0);
    test_decrypt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
